// File: rtl/knn_sort_pkg.sv
// Shared definitions for the KNN bitonic sorting pipeline: stage count helper,
// default lane layout and the value presented on empty lanes.
package knn_sort_pkg;

    localparam int DEF_W      = 16;
    localparam int DEF_TYPE_W = 3;

    // Key value carried by (and presented on) masked lanes; wide enough for any W.
    localparam logic [63:0] RESET_KEY = 64'd0;

    // One lane of a vector at the default widths: key, tag and occupancy flag.
    typedef struct packed {
        logic [DEF_W-1:0]      key;
        logic [DEF_TYPE_W-1:0] typ;
        logic                  vld;
    } lane_t;

    // Number of bitonic columns (and register stages) for 2**log2n lanes.
    function automatic int stage_count(input int log2n);
        return (log2n * (log2n + 1)) / 2;
    endfunction

endpackage

// File: rtl/sort_cas.sv
// Single compare-exchange element of the bitonic network. Purely combinational.
// Empty lanes behave as keys beyond the far end of the final order, so they
// drift to the high indices regardless of the requested direction.
module sort_cas #(
    parameter int W      = 16,
    parameter int TYPE_W = 3
) (
    input  logic [W-1:0]      a_key,
    input  logic [TYPE_W-1:0] a_type,
    input  logic              a_vld,
    input  logic [W-1:0]      b_key,
    input  logic [TYPE_W-1:0] b_type,
    input  logic              b_vld,
    input  logic              dir,
    input  logic              fin,
    output logic [W-1:0]      lo_key,
    output logic [TYPE_W-1:0] lo_type,
    output logic              lo_vld,
    output logic [W-1:0]      hi_key,
    output logic [TYPE_W-1:0] hi_type,
    output logic              hi_vld
);

    logic a_gt_b;
    logic b_gt_a;
    logic swap;

    // Order the pair in the extended key space and route both lanes.
    always_comb begin
        a_gt_b = 1'b0;
        b_gt_a = 1'b0;
        case ({a_vld, b_vld})
            2'b11: begin
                a_gt_b = (a_key > b_key);
                b_gt_a = (b_key > a_key);
            end
            2'b01: begin
                a_gt_b = fin;
                b_gt_a = ~fin;
            end
            2'b10: begin
                a_gt_b = ~fin;
                b_gt_a = fin;
            end
            default: begin
                a_gt_b = 1'b0;
                b_gt_a = 1'b0;
            end
        endcase
        swap = dir ? a_gt_b : b_gt_a;
        if (swap) begin
            lo_key  = b_key;
            lo_type = b_type;
            lo_vld  = b_vld;
            hi_key  = a_key;
            hi_type = a_type;
            hi_vld  = a_vld;
        end else begin
            lo_key  = a_key;
            lo_type = a_type;
            lo_vld  = a_vld;
            hi_key  = b_key;
            hi_type = b_type;
            hi_vld  = b_vld;
        end
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter for 2**LOG2N (key, tag) lanes with per-vector
// direction and lane mask. One bitonic column per register stage; the whole
// pipe advances together under a single global advance signal.
module bitonic_sort_pipe
    import knn_sort_pkg::*;
#(
    parameter int LOG2N  = 3,
    parameter int W      = 16,
    parameter int TYPE_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      ascending,
    input  logic [(1<<LOG2N)-1:0]     in_mask,
    input  logic [W*(1<<LOG2N)-1:0]   in_key,
    input  logic [TYPE_W*(1<<LOG2N)-1:0] in_type,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(1<<LOG2N)-1:0]     out_mask,
    output logic [W*(1<<LOG2N)-1:0]   out_key,
    output logic [TYPE_W*(1<<LOG2N)-1:0] out_type,
    output logic [LOG2N:0]            out_count
);

    localparam int N  = 1 << LOG2N;
    localparam int S  = stage_count(LOG2N);
    localparam int CW = LOG2N + 1;

    // Input lanes after masking: empty lanes carry a zero key and tag.
    logic [W-1:0]      in_key_m  [N];
    logic [TYPE_W-1:0] in_type_m [N];
    logic [CW-1:0]     in_cnt;

    // Column inputs (previous register or the input port) and column results.
    logic [W-1:0]      src_key  [S][N];
    logic [TYPE_W-1:0] src_type [S][N];
    logic              src_vld  [S][N];
    logic              src_v    [S];
    logic              src_asc  [S];
    logic [CW-1:0]     src_cnt  [S];
    logic [W-1:0]      res_key  [S][N];
    logic [TYPE_W-1:0] res_type [S][N];
    logic              res_vld  [S][N];

    // Stage registers.
    logic [W-1:0]      st_key  [S][N];
    logic [TYPE_W-1:0] st_type [S][N];
    logic              st_vld  [S][N];
    logic              st_v    [S];
    logic              st_asc  [S];
    logic [CW-1:0]     st_cnt  [S];

    logic adv;

    assign adv      = ~st_v[S-1] | out_ready;
    assign in_ready = adv;

    // Blank empty lanes and count the occupied ones for this vector.
    always_comb begin
        in_cnt = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            in_key_m[i]  = in_mask[i] ? in_key[W*i +: W] : RESET_KEY[W-1:0];
            in_type_m[i] = in_mask[i] ? in_type[TYPE_W*i +: TYPE_W] : {TYPE_W{1'b0}};
            in_cnt       = in_cnt + CW'(in_mask[i]);
        end
    end

    // Column c reads the port (c = 0) or the register behind it.
    for (genvar c = 0; c < S; c++) begin : g_src
        if (c == 0) begin : g_in
            assign src_v[c]   = in_valid;
            assign src_asc[c] = ascending;
            assign src_cnt[c] = in_cnt;
        end else begin : g_reg
            assign src_v[c]   = st_v[c-1];
            assign src_asc[c] = st_asc[c-1];
            assign src_cnt[c] = st_cnt[c-1];
        end
        for (genvar i = 0; i < N; i++) begin : g_lane
            if (c == 0) begin : g_in
                assign src_key[c][i]  = in_key_m[i];
                assign src_type[c][i] = in_type_m[i];
                assign src_vld[c][i]  = in_mask[i];
            end else begin : g_reg
                assign src_key[c][i]  = st_key[c-1][i];
                assign src_type[c][i] = st_type[c-1][i];
                assign src_vld[c][i]  = st_vld[c-1][i];
            end
        end
    end

    // Bitonic network: merge size 2**k, partner distance 2**j, one column per (k, j).
    for (genvar k = 1; k <= LOG2N; k++) begin : g_k
        for (genvar jj = 0; jj < k; jj++) begin : g_j
            localparam int J = k - 1 - jj;
            localparam int C = (k * (k - 1)) / 2 + jj;
            for (genvar i = 0; i < N; i++) begin : g_i
                localparam int P = i ^ (1 << J);
                if (P > i) begin : g_cas
                    localparam logic BK = (((i >> k) & 1) != 0);
                    sort_cas #(
                        .W      (W),
                        .TYPE_W (TYPE_W)
                    ) u_cas (
                        .a_key   (src_key[C][i]),
                        .a_type  (src_type[C][i]),
                        .a_vld   (src_vld[C][i]),
                        .b_key   (src_key[C][P]),
                        .b_type  (src_type[C][P]),
                        .b_vld   (src_vld[C][P]),
                        .dir     (src_asc[C] ^ BK),
                        .fin     (src_asc[C]),
                        .lo_key  (res_key[C][i]),
                        .lo_type (res_type[C][i]),
                        .lo_vld  (res_vld[C][i]),
                        .hi_key  (res_key[C][P]),
                        .hi_type (res_type[C][P]),
                        .hi_vld  (res_vld[C][P])
                    );
                end
            end
        end
    end

    // Advance every stage together; hold the whole pipe while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < S; c++) begin
                st_v[c]   <= 1'b0;
                st_asc[c] <= 1'b0;
                st_cnt[c] <= {CW{1'b0}};
                for (int i = 0; i < N; i++) begin
                    st_key[c][i]  <= RESET_KEY[W-1:0];
                    st_type[c][i] <= {TYPE_W{1'b0}};
                    st_vld[c][i]  <= 1'b0;
                end
            end
        end else if (adv) begin
            for (int c = 0; c < S; c++) begin
                st_v[c]   <= src_v[c];
                st_asc[c] <= src_asc[c];
                st_cnt[c] <= src_cnt[c];
                for (int i = 0; i < N; i++) begin
                    st_key[c][i]  <= res_key[c][i];
                    st_type[c][i] <= res_type[c][i];
                    st_vld[c][i]  <= res_vld[c][i];
                end
            end
        end
    end

    assign out_valid = st_v[S-1];
    assign out_count = st_cnt[S-1];

    for (genvar i = 0; i < N; i++) begin : g_out
        assign out_key[W*i +: W]           = st_key[S-1][i];
        assign out_type[TYPE_W*i +: TYPE_W] = st_type[S-1][i];
        assign out_mask[i]                 = st_vld[S-1][i];
    end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed self-checking bench for bitonic_sort_pipe at N=8, W=16, TYPE_W=3.
module tb_bitonic_sort_pipe;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int W     = 16;
    localparam int TW    = 3;
    localparam int S     = 6;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            ascending;
    logic [N-1:0]    in_mask;
    logic [W*N-1:0]  in_key;
    logic [TW*N-1:0] in_type;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_mask;
    logic [W*N-1:0]  out_key;
    logic [TW*N-1:0] out_type;
    logic [CW-1:0]   out_count;

    typedef struct packed {
        logic [W*N-1:0]  key;
        logic [TW*N-1:0] typ;
        logic [N-1:0]    mask;
        logic [CW-1:0]   cnt;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rx_cnt   = 0;
    int   rx_first = -1;
    int   rx_last  = -1;
    logic sb_en    = 1'b0;
    exp_t sb[$];
    exp_t e;

    bitonic_sort_pipe #(.LOG2N(LOG2N), .W(W), .TYPE_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ascending (ascending),
        .in_mask   (in_mask),
        .in_key    (in_key),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_key   (out_key),
        .out_type  (out_type),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [TW-1:0] tag_of(input logic [W-1:0] k);
        return k[2:0] ^ k[5:3];
    endfunction

    function automatic logic [TW*N-1:0] tags_of(input logic [W*N-1:0] k);
        logic [TW*N-1:0] r;
        for (int i = 0; i < N; i++) r[TW*i +: TW] = tag_of(k[W*i +: W]);
        return r;
    endfunction

    function automatic logic [W*N-1:0] pack_keys(input int a[N]);
        logic [W*N-1:0] r;
        for (int i = 0; i < N; i++) r[W*i +: W] = W'(a[i]);
        return r;
    endfunction

    function automatic logic [TW*N-1:0] pack_tags(input int a[N]);
        logic [TW*N-1:0] r;
        for (int i = 0; i < N; i++) r[TW*i +: TW] = TW'(a[i]);
        return r;
    endfunction

    // Reference: gather occupied keys, plain bubble sort, pack from lane 0.
    function automatic exp_t model(input logic asc, input logic [N-1:0] m, input logic [W*N-1:0] k);
        exp_t         r;
        logic [W-1:0] v[N];
        logic [W-1:0] t;
        int           n;
        r = '0;
        n = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = '0;
            if (m[i]) begin
                v[n] = k[W*i +: W];
                n++;
            end
        end
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n - 1 - a; b++)
                if (asc ? (v[b] > v[b+1]) : (v[b] < v[b+1])) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        for (int i = 0; i < n; i++) begin
            r.key[W*i +: W]   = v[i];
            r.typ[TW*i +: TW] = tag_of(v[i]);
            r.mask[i]         = 1'b1;
        end
        r.cnt = CW'(n);
        return r;
    endfunction

    // Drive one vector and hold it until it is accepted; returns 1 time unit after the transfer edge.
    task automatic push_vec(input logic asc, input logic [N-1:0] m, input logic [W*N-1:0] k,
                            input logic [TW*N-1:0] t);
        int guard;
        guard     = 0;
        ascending = asc;
        in_mask   = m;
        in_key    = k;
        in_type   = t;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_eq("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare each delivered vector against the model, then record accepted inputs.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("sb_key", out_key, e.key);
                    check_eq("sb_type", out_type, e.typ);
                    check_eq("sb_mask", out_mask, e.mask);
                    check_eq("sb_count", out_count, e.cnt);
                    rx_cnt++;
                    if (rx_first < 0) rx_first = cyc;
                    rx_last = cyc;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(ascending, in_mask, in_key));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int              kv[N];
        int              tv[N];
        int              ev[N];
        logic [W*N-1:0]  k1;
        logic [TW*N-1:0] t1;
        logic [TW*N-1:0] tmask;
        logic [5:0]      tie;
        logic [W*N-1:0]  rk;
        logic            changed;
        logic            snap_ok;
        logic            seen;
        logic [W*N-1:0]  snap_key;
        logic [TW*N-1:0] snap_type;
        logic [N-1:0]    snap_mask;
        time             t0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ascending = 1'b1;
        in_mask   = '0;
        in_key    = '0;
        in_type   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_mask", out_mask, 8'h00);
        check_eq("rst_out_count", out_count, 4'd0);
        check_eq("rst_out_key", out_key, 128'd0);
        check_eq("rst_out_type", out_type, 24'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);

        // Test 1: ascending, full mask.
        kv = '{7, 3, 9, 1, 9, 0, 65535, 4};
        tv = '{0, 1, 2, 3, 4, 5, 6, 7};
        k1 = pack_keys(kv);
        t1 = pack_tags(tv);
        push_vec(1'b1, 8'hFF, k1, t1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("t1_not_early", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq("t1_valid", out_valid, 1'b1);
        ev = '{0, 1, 3, 4, 7, 9, 9, 65535};
        check_eq("t1_key", out_key, pack_keys(ev));
        ev = '{5, 3, 1, 7, 0, 0, 0, 6};
        tmask = 24'hFFFFFF;
        tmask[15 +: 6] = 6'd0;
        check_eq("t1_type", out_type & tmask, pack_tags(ev));
        tie = out_type[15 +: 6];
        check_eq("t1_tie_tags", (tie == {3'd4, 3'd2}) || (tie == {3'd2, 3'd4}), 1'b1);
        check_eq("t1_mask", out_mask, 8'hFF);
        check_eq("t1_count", out_count, 4'd8);

        // Test 2: descending, partial mask; garbage keys on empty lanes.
        kv = '{5, 16'hFFFF, 2, 8, 16'hABCD, 1, 16'h1234, 0};
        push_vec(1'b0, 8'b0010_1101, pack_keys(kv), t1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t2_valid", out_valid, 1'b1);
        ev = '{8, 5, 2, 1, 0, 0, 0, 0};
        check_eq("t2_key", out_key, pack_keys(ev));
        ev = '{3, 0, 2, 5, 0, 0, 0, 0};
        check_eq("t2_type", out_type, pack_tags(ev));
        check_eq("t2_mask", out_mask, 8'h0F);
        check_eq("t2_count", out_count, 4'd4);

        // Test 6: all lanes empty.
        push_vec(1'b1, 8'h00, pack_keys(kv), t1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t6_valid", out_valid, 1'b1);
        check_eq("t6_mask", out_mask, 8'h00);
        check_eq("t6_count", out_count, 4'd0);
        check_eq("t6_key", out_key, 128'd0);
        check_eq("t6_type", out_type, 24'd0);
        repeat (2) @(posedge clk);
        #1;

        // Test 3: 20 back-to-back vectors, alternating direction.
        sb_en    = 1'b1;
        rx_cnt   = 0;
        rx_first = -1;
        t0       = $time;
        for (int v = 0; v < 20; v++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            push_vec(v[0] == 1'b0, (v % 4 == 0) ? 8'hFF : 8'($urandom), rk, tags_of(rk));
        end
        check_eq("t3_in_ready_held", ($time - t0) == 200, 1'b1);
        repeat (S + 2) @(posedge clk);
        #1;
        check_eq("t3_drained", sb.size(), 0);
        check_eq("t3_rx_count", rx_cnt, 20);
        check_eq("t3_consecutive", rx_last - rx_first, 19);

        // Test 4: downstream stall for 10 cycles while input keeps coming.
        rx_cnt = 0;
        fork
            begin
                for (int v = 0; v < 12; v++) begin
                    rk = {$urandom, $urandom, $urandom, $urandom};
                    push_vec(v[0] == 1'b1, 8'($urandom) | 8'h01, rk, tags_of(rk));
                end
            end
            begin
                out_ready = 1'b0;
                changed   = 1'b0;
                snap_ok   = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!snap_ok) begin
                            snap_ok   = 1'b1;
                            snap_key  = out_key;
                            snap_type = out_type;
                            snap_mask = out_mask;
                        end else if (out_key !== snap_key || out_type !== snap_type ||
                                     out_mask !== snap_mask) begin
                            changed = 1'b1;
                        end
                    end
                end
                check_eq("t4_in_ready_low", in_ready, 1'b0);
                check_eq("t4_out_valid_held", snap_ok, 1'b1);
                check_eq("t4_stable", changed, 1'b0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (S + 4) @(posedge clk);
        #1;
        check_eq("t4_drained", sb.size(), 0);
        check_eq("t4_rx_count", rx_cnt, 12);
        sb_en = 1'b0;

        // Test 5: reset with four vectors in flight.
        for (int v = 0; v < 4; v++) push_vec(1'b1, 8'hFF, k1, t1);
        rst = 1'b1;
        #1;
        check_eq("t5_valid_now", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("t5_no_ghost", seen, 1'b0);
        @(posedge clk);
        #1;
        push_vec(1'b1, 8'hFF, k1, t1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t5_new_valid", out_valid, 1'b1);
        ev = '{0, 1, 3, 4, 7, 9, 9, 65535};
        check_eq("t5_new_key", out_key, pack_keys(ev));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
